// File: rtl/riscv_store_monitor.sv
// End-of-test monitor on the core's data-memory write port: classifies stores as
// pass signature, scratch or illegal, runs a watchdog and reports sticky status.
module riscv_store_monitor #(
    parameter logic [31:0] PASS_ADDR       = 32'h0000_0000,
    parameter logic [31:0] PASS_DATA       = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR    = 32'd96,
    parameter int          WATCHDOG_CYCLES = 1000,
    parameter int          CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    input  logic [31:0]      PC,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      last_store_addr,
    output logic [31:0]      last_store_data,
    output logic [31:0]      fail_pc
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        V_NONE    = 2'd0,
        V_PASS    = 2'd1,
        V_FAIL    = 2'd2,
        V_SCRATCH = 2'd3
    } verdict_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    // Watchdog compares the pre-increment count, so expiry lands on the N-th RUN edge.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 32'sd1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t            state_r;
    verdict_t          verdict_s;
    logic              wd_expire_s;
    logic              done_r, pass_r, fail_r, timeout_r;
    logic [CNT_W-1:0]  store_count_r, cycle_count_r;
    logic [31:0]       last_addr_r, last_data_r, fail_pc_r;

    // Classify the store presented this cycle; PASS_ADDR rules take priority over scratch.
    always_comb begin
        verdict_s = V_NONE;
        if (!MemWrite) begin
            verdict_s = V_NONE;
        end else if (DataAdr == PASS_ADDR) begin
            if (WriteData == PASS_DATA) begin
                verdict_s = V_PASS;
            end else begin
                verdict_s = V_FAIL;
            end
        end else if (DataAdr == SCRATCH_ADDR) begin
            verdict_s = V_SCRATCH;
        end else begin
            verdict_s = V_FAIL;
        end
    end

    assign wd_expire_s = (cycle_count_r == WD_LAST);

    // Monitor FSM, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            timeout_r     <= 1'b0;
            store_count_r <= '0;
            cycle_count_r <= '0;
            last_addr_r   <= 32'h0000_0000;
            last_data_r   <= 32'h0000_0000;
            fail_pc_r     <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        cycle_count_r <= sat_inc(cycle_count_r);
                        if (MemWrite) begin
                            store_count_r <= sat_inc(store_count_r);
                            last_addr_r   <= DataAdr;
                            last_data_r   <= WriteData;
                        end else begin
                            store_count_r <= store_count_r;
                        end
                        // A terminal store on the expiry edge beats the watchdog.
                        case (verdict_s)
                            V_PASS: begin
                                state_r <= ST_PASS;
                                done_r  <= 1'b1;
                                pass_r  <= 1'b1;
                            end
                            V_FAIL: begin
                                state_r   <= ST_FAIL;
                                done_r    <= 1'b1;
                                fail_r    <= 1'b1;
                                fail_pc_r <= PC;
                            end
                            default: begin
                                if (wd_expire_s) begin
                                    state_r   <= ST_TIMEOUT;
                                    done_r    <= 1'b1;
                                    timeout_r <= 1'b1;
                                end else begin
                                    state_r <= ST_RUN;
                                end
                            end
                        endcase
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b0;
                    pass_r    <= 1'b0;
                    fail_r    <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign done            = done_r;
    assign pass            = pass_r;
    assign fail            = fail_r;
    assign timeout         = timeout_r;
    assign store_count     = store_count_r;
    assign cycle_count     = cycle_count_r;
    assign last_store_addr = last_addr_r;
    assign last_store_data = last_data_r;
    assign fail_pc         = fail_pc_r;

endmodule

// File: tb/tb_riscv_store_monitor.sv
// Directed bench for riscv_store_monitor: vector table for store classification
// plus hand sequences for watchdog, pause, expiry race and asynchronous reset.
module tb_riscv_store_monitor;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] PC;
    logic        done, pass, fail, timeout;
    logic [15:0] store_count, cycle_count;
    logic [31:0] last_store_addr, last_store_data, fail_pc;

    int compared = 0;
    int mismatched = 0;

    riscv_store_monitor #(
        .PASS_ADDR      (32'h0000_0000),
        .PASS_DATA      (32'd25),
        .SCRATCH_ADDR   (32'd96),
        .WATCHDOG_CYCLES(40),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .MemWrite       (MemWrite),
        .DataAdr        (DataAdr),
        .WriteData      (WriteData),
        .PC             (PC),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .store_count    (store_count),
        .cycle_count    (cycle_count),
        .last_store_addr(last_store_addr),
        .last_store_data(last_store_data),
        .fail_pc        (fail_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          en;
        bit          mw;
        logic [31:0] adr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [3:0]  st;   // {done, pass, fail, timeout}
        logic [15:0] sc;
        logic [15:0] cc;
        logic [31:0] la;
        logic [31:0] ld;
        logic [31:0] fpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit rst, bit en, bit mw, logic [31:0] adr, logic [31:0] data,
                                 logic [31:0] pc, logic [3:0] st, logic [15:0] sc, logic [15:0] cc,
                                 logic [31:0] la, logic [31:0] ld, logic [31:0] fpc);
        vec_t v;
        v.rst = rst; v.en = en; v.mw = mw; v.adr = adr; v.data = data; v.pc = pc;
        v.st = st; v.sc = sc; v.cc = cc; v.la = la; v.ld = ld; v.fpc = fpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [15:0] sc,
                             input logic [15:0] cc, input logic [31:0] la, input logic [31:0] ld,
                             input logic [31:0] fpc);
        check({tag, ".status"}, {28'd0, done, pass, fail, timeout}, {28'd0, st});
        check({tag, ".store_count"}, {16'd0, store_count}, {16'd0, sc});
        check({tag, ".cycle_count"}, {16'd0, cycle_count}, {16'd0, cc});
        check({tag, ".last_addr"}, last_store_addr, la);
        check({tag, ".last_data"}, last_store_data, ld);
        check({tag, ".fail_pc"}, fail_pc, fpc);
    endtask

    // Drive one cycle of inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input bit en, input bit mw, input logic [31:0] adr,
                        input logic [31:0] data, input logic [31:0] pc);
        enable = en; MemWrite = mw; DataAdr = adr; WriteData = data; PC = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; MemWrite = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        reset = 1'b0; enable = 1'b0; MemWrite = 1'b0;
        DataAdr = 32'd0; WriteData = 32'd0; PC = 32'd0;
        #1;
        check_all("reset_state", 4'b0000, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Pass scenario with pause, then stores ignored after PASS.
        vecs.push_back(mkv(0, 0, 1, 32'h100, 32'd5, 32'h0, 4'b0000, 16'd0, 16'd0, 32'd0,   32'd0,  32'd0));
        vecs.push_back(mkv(0, 1, 1, 32'h100, 32'd5, 32'h0, 4'b0000, 16'd0, 16'd0, 32'd0,   32'd0,  32'd0));
        vecs.push_back(mkv(0, 1, 1, 32'd96,  32'd7, 32'h8, 4'b0000, 16'd1, 16'd1, 32'd96,  32'd7,  32'd0));
        vecs.push_back(mkv(0, 1, 0, 32'h100, 32'd1, 32'hc, 4'b0000, 16'd1, 16'd2, 32'd96,  32'd7,  32'd0));
        vecs.push_back(mkv(0, 0, 1, 32'h100, 32'd1, 32'hc, 4'b0000, 16'd1, 16'd2, 32'd96,  32'd7,  32'd0));
        vecs.push_back(mkv(0, 1, 1, 32'd0,   32'd25,32'h10,4'b1100, 16'd2, 16'd3, 32'd0,   32'd25, 32'd0));
        vecs.push_back(mkv(0, 1, 1, 32'h100, 32'd9, 32'h14,4'b1100, 16'd2, 16'd3, 32'd0,   32'd25, 32'd0));
        // Wrong data at pass address.
        vecs.push_back(mkv(1, 1, 0, 32'd0,   32'd0, 32'h0, 4'b0000, 16'd0, 16'd0, 32'd0,   32'd0,  32'd0));
        vecs.push_back(mkv(0, 1, 1, 32'd0,   32'd24,32'h44,4'b1010, 16'd1, 16'd1, 32'd0,   32'd24, 32'h44));
        vecs.push_back(mkv(0, 1, 1, 32'd0,   32'd25,32'h48,4'b1010, 16'd1, 16'd1, 32'd0,   32'd24, 32'h44));
        vecs.push_back(mkv(0, 1, 1, 32'd96,  32'd3, 32'h4c,4'b1010, 16'd1, 16'd1, 32'd0,   32'd24, 32'h44));
        // Illegal address.
        vecs.push_back(mkv(1, 1, 0, 32'd0,   32'd0, 32'h0, 4'b0000, 16'd0, 16'd0, 32'd0,   32'd0,  32'd0));
        vecs.push_back(mkv(0, 1, 1, 32'h100, 32'hdead, 32'h20, 4'b1010, 16'd1, 16'd1, 32'h100, 32'hdead, 32'h20));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].en, vecs[i].mw, vecs[i].adr, vecs[i].data, vecs[i].pc);
            check_all($sformatf("row%0d", i), vecs[i].st, vecs[i].sc, vecs[i].cc,
                      vecs[i].la, vecs[i].ld, vecs[i].fpc);
        end

        // Watchdog with scratch stores on odd edges.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 32'd0);
        for (int e = 1; e <= 39; e++) step(1, e[0], 32'd96, e, 32'd0);
        check_all("wd_edge39", 4'b0000, 16'd20, 16'd39, 32'd96, 32'd39, 32'd0);
        step(1, 0, 32'd0, 32'd0, 32'd0);
        check_all("wd_edge40", 4'b1001, 16'd20, 16'd40, 32'd96, 32'd39, 32'd0);
        step(1, 1, 32'h100, 32'd1, 32'h30);
        check_all("wd_sticky", 4'b1001, 16'd20, 16'd40, 32'd96, 32'd39, 32'd0);

        // Watchdog with 5 paused edges: expiry 5 edges later.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 32'd0);
        n = 0;
        while (!timeout && n < 100) begin
            n++;
            step(!(n > 20 && n <= 25), 1, 32'd96, n, 32'd0);
        end
        check("pause_expiry_edge", n, 32'd45);
        check_all("pause_wd", 4'b1001, 16'd40, 16'd40, 32'd96, 32'd45, 32'd0);

        // Pass store on the exact expiry edge.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 32'd0);
        for (int e = 1; e <= 39; e++) step(1, 0, 32'd0, 32'd0, 32'd0);
        step(1, 1, 32'd0, 32'd25, 32'h80);
        check_all("expiry_pass", 4'b1100, 16'd1, 16'd40, 32'd0, 32'd25, 32'd0);

        // Asynchronous reset mid-RUN, re-arm, then reset while in PASS.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 32'd0);
        for (int e = 1; e <= 3; e++) step(1, 1, 32'd96, e, 32'd0);
        check_all("pre_reset_run", 4'b0000, 16'd3, 16'd3, 32'd96, 32'd3, 32'd0);
        reset = 1'b0;
        #1;
        check_all("async_reset_run", 4'b0000, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);
        #1;
        reset = 1'b1;
        step(1, 1, 32'd0, 32'd25, 32'h4);
        check_all("rearm_store_ignored", 4'b0000, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);
        step(1, 1, 32'd0, 32'd25, 32'h8);
        check_all("rearm_pass", 4'b1100, 16'd1, 16'd1, 32'd0, 32'd25, 32'd0);
        reset = 1'b0;
        #1;
        check_all("async_reset_pass", 4'b0000, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);
        #1;
        reset = 1'b1;
        step(0, 1, 32'd0, 32'd25, 32'hc);
        check_all("idle_after_reset", 4'b0000, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
